// File: rtl/mac_rx_parser.sv
// mac_rx_parser
//   Byte-wide Ethernet receive parser on the GMII side. Strips the preamble and
//   SFD, captures the destination/source/ethertype header, and forwards the
//   payload with the FCS removed as a valid/last stream. At the end of each frame
//   it reports CRC-32, length, PHY-error and address-match status, and it keeps
//   counters of good and bad frames.
// Ports
//   in_rxc, in_rst_n          receive clock, asynchronous active-low reset
//   in_rxdv, in_rxd, in_rxer  GMII receive envelope, data byte, PHY error
//   out_valid/data/last       payload stream, one byte per cycle, no backpressure
//   out_hdr_valid             pulse: out_dest_mac/out_src_mac/out_ether_type updated
//   out_done, out_status      end-of-frame pulse, {crc_err, len_err, phy_err, addr_miss}
//   out_frames_ok/bad         wrapping frame counters
module mac_rx_parser #(
  parameter logic [47:0] MAC_ADDR    = 48'h02_00_00_00_00_01,
  parameter bit          PROMISC     = 1'b0,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          CNT_W       = 16
) (
  input  logic             in_rxc,
  input  logic             in_rst_n,
  input  logic             in_rxdv,
  input  logic [7:0]       in_rxd,
  input  logic             in_rxer,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_hdr_valid,
  output logic [47:0]      out_dest_mac,
  output logic [47:0]      out_src_mac,
  output logic [15:0]      out_ether_type,
  output logic             out_done,
  output logic [3:0]       out_status,
  output logic [CNT_W-1:0] out_frames_ok,
  output logic [CNT_W-1:0] out_frames_bad
);

  localparam int          PCW         = $clog2(MAX_PAYLOAD + 1);
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_HEADER   = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_DROP     = 3'd4
  } state_t;

  // Reflected CRC-32 update for one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data_in);
    logic [31:0] c;
    c = crc_in ^ {24'h00_0000, data_in};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = {1'b0, c[31:1]} ^ 32'hEDB8_8320;
      else      c = {1'b0, c[31:1]};
    end
    return c;
  endfunction

  // Group addresses (I/G bit = bit 0 of the first wire byte) always pass.
  function automatic logic is_addr_miss(input logic [47:0] dest);
    return (PROMISC == 1'b0) && (dest != MAC_ADDR) && (dest[40] == 1'b0);
  endfunction

  state_t          state_r, next_state_s;
  logic [2:0]      pre_cnt_r;
  logic [3:0]      hdr_cnt_r;
  logic [103:0]    hdr_sh_r;
  logic [39:0]     dl_r;        // 5-byte delay line, oldest byte in [39:32]
  logic [2:0]      dl_cnt_r;
  logic [PCW-1:0]  pay_cnt_r;   // payload bytes released from the delay line
  logic [31:0]     crc_r;
  logic            hdr_seen_r, len_err_r, phy_err_r, miss_r;
  logic            done_pend_r;
  logic [3:0]      pend_status_r;

  logic hdr_start_s, crc_upd_s, hdr_byte_s, hdr_last_s;
  logic pay_shift_s, pay_emit_s, trunc_s;
  logic end_last_s, end_done_s, end_len_err_s;
  logic rxer_hit_s, fin_valid_s;
  logic [3:0] status_s, fin_status_s;

  assign rxer_hit_s   = in_rxer & ((state_r == ST_HEADER) | (state_r == ST_PAYLOAD) |
                                   ((state_r == ST_DROP) & hdr_seen_r));
  assign status_s     = {crc_r != CRC_RESIDUE, len_err_r | end_len_err_s,
                         phy_err_r | rxer_hit_s, miss_r};
  // A frame that ended with out_last reports one cycle later from the pending slot.
  assign fin_valid_s  = done_pend_r | end_done_s;
  assign fin_status_s = done_pend_r ? pend_status_r : status_s;

  // State register; DROP out of reset so a frame already in flight is ignored.
  always_ff @(posedge in_rxc or negedge in_rst_n) begin
    if (!in_rst_n) state_r <= ST_DROP;
    else           state_r <= next_state_s;
  end

  // Next-state and per-byte control strobes.
  always_comb begin
    next_state_s  = state_r;
    hdr_start_s   = 1'b0;
    crc_upd_s     = 1'b0;
    hdr_byte_s    = 1'b0;
    hdr_last_s    = 1'b0;
    pay_shift_s   = 1'b0;
    pay_emit_s    = 1'b0;
    trunc_s       = 1'b0;
    end_last_s    = 1'b0;
    end_done_s    = 1'b0;
    end_len_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_rxdv) next_state_s = (in_rxd == PRE_BYTE) ? ST_PREAMBLE : ST_DROP;
        else         next_state_s = ST_IDLE;
      end
      ST_PREAMBLE: begin
        if (!in_rxdv) begin
          next_state_s = ST_IDLE;
        end else if (in_rxd == SFD_BYTE) begin
          next_state_s = ST_HEADER;
          hdr_start_s  = 1'b1;
        end else if (in_rxd == PRE_BYTE) begin
          next_state_s = (pre_cnt_r == 3'd7) ? ST_DROP : ST_PREAMBLE;
        end else begin
          next_state_s = ST_DROP;
        end
      end
      ST_HEADER: begin
        if (in_rxdv) begin
          crc_upd_s  = 1'b1;
          hdr_byte_s = 1'b1;
          if (hdr_cnt_r == 4'd13) begin
            hdr_last_s   = 1'b1;
            next_state_s = ST_PAYLOAD;
          end else begin
            next_state_s = ST_HEADER;
          end
        end else begin
          end_done_s    = 1'b1;
          end_len_err_s = 1'b1;
          next_state_s  = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (in_rxdv) begin
          crc_upd_s   = 1'b1;
          pay_shift_s = 1'b1;
          if (dl_cnt_r == 3'd5) begin
            pay_emit_s = 1'b1;
            if (pay_cnt_r == PCW'(MAX_PAYLOAD - 1)) begin
              trunc_s      = 1'b1;
              next_state_s = ST_DROP;
            end else begin
              next_state_s = ST_PAYLOAD;
            end
          end else begin
            next_state_s = ST_PAYLOAD;
          end
        end else begin
          // Delay line now holds the last payload byte followed by the 4 FCS bytes.
          if (dl_cnt_r == 3'd5) begin
            end_len_err_s = ((int'(pay_cnt_r) + 1) < MIN_PAYLOAD);
            if (miss_r) end_done_s = 1'b1;
            else        end_last_s = 1'b1;
          end else begin
            end_len_err_s = 1'b1;
            end_done_s    = 1'b1;
          end
          next_state_s = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (in_rxdv) begin
          crc_upd_s    = hdr_seen_r;
          next_state_s = ST_DROP;
        end else begin
          end_done_s   = hdr_seen_r;
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: preamble count, header capture, delay line, CRC, status and outputs.
  always_ff @(posedge in_rxc or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pre_cnt_r      <= 3'd0;
      hdr_cnt_r      <= 4'd0;
      hdr_sh_r       <= {104{1'b0}};
      dl_r           <= 40'h00_0000_0000;
      dl_cnt_r       <= 3'd0;
      pay_cnt_r      <= {PCW{1'b0}};
      crc_r          <= CRC_INIT;
      hdr_seen_r     <= 1'b0;
      len_err_r      <= 1'b0;
      phy_err_r      <= 1'b0;
      miss_r         <= 1'b0;
      done_pend_r    <= 1'b0;
      pend_status_r  <= 4'h0;
      out_valid      <= 1'b0;
      out_data       <= 8'h00;
      out_last       <= 1'b0;
      out_hdr_valid  <= 1'b0;
      out_dest_mac   <= 48'h0000_0000_0000;
      out_src_mac    <= 48'h0000_0000_0000;
      out_ether_type <= 16'h0000;
      out_done       <= 1'b0;
      out_status     <= 4'h0;
      out_frames_ok  <= {CNT_W{1'b0}};
      out_frames_bad <= {CNT_W{1'b0}};
    end else begin
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_hdr_valid <= 1'b0;
      out_done      <= 1'b0;

      if (state_r == ST_IDLE) begin
        pre_cnt_r <= 3'd1;
      end else if ((state_r == ST_PREAMBLE) && in_rxdv && (in_rxd == PRE_BYTE) && (pre_cnt_r != 3'd7)) begin
        pre_cnt_r <= pre_cnt_r + 3'd1;
      end

      if (hdr_start_s) begin
        crc_r      <= CRC_INIT;
        hdr_cnt_r  <= 4'd0;
        dl_cnt_r   <= 3'd0;
        pay_cnt_r  <= {PCW{1'b0}};
        hdr_seen_r <= 1'b1;
        len_err_r  <= 1'b0;
        phy_err_r  <= 1'b0;
        miss_r     <= 1'b0;
      end else if (crc_upd_s) begin
        crc_r <= crc32_byte(crc_r, in_rxd);
      end

      if (rxer_hit_s) phy_err_r <= 1'b1;

      if (hdr_byte_s) begin
        hdr_sh_r  <= {hdr_sh_r[95:0], in_rxd};
        hdr_cnt_r <= hdr_cnt_r + 4'd1;
      end

      if (hdr_last_s) begin
        out_dest_mac   <= hdr_sh_r[103:56];
        out_src_mac    <= hdr_sh_r[55:8];
        out_ether_type <= {hdr_sh_r[7:0], in_rxd};
        out_hdr_valid  <= 1'b1;
        miss_r         <= is_addr_miss(hdr_sh_r[103:56]);
      end

      if (pay_shift_s) begin
        dl_r <= {dl_r[31:0], in_rxd};
        if (dl_cnt_r != 3'd5) dl_cnt_r <= dl_cnt_r + 3'd1;
      end

      // Oldest byte leaves only once five newer bytes sit behind it (it cannot be FCS).
      if (pay_emit_s) begin
        pay_cnt_r <= pay_cnt_r + PCW'(1);
        if (!miss_r) begin
          out_valid <= 1'b1;
          out_data  <= dl_r[39:32];
          out_last  <= trunc_s;
        end
      end

      if (trunc_s) len_err_r <= 1'b1;

      done_pend_r <= 1'b0;
      if (end_last_s) begin
        out_valid     <= 1'b1;
        out_data      <= dl_r[39:32];
        out_last      <= 1'b1;
        done_pend_r   <= 1'b1;
        pend_status_r <= status_s;
      end

      if (end_last_s || end_done_s) hdr_seen_r <= 1'b0;

      if (fin_valid_s) begin
        out_done   <= 1'b1;
        out_status <= fin_status_s;
        if (fin_status_s == 4'h0) out_frames_ok  <= out_frames_ok + CNT_W'(1);
        else                      out_frames_bad <= out_frames_bad + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mac_rx_parser.sv
// Self-checking bench for mac_rx_parser: directed and randomized frames checked
// against a frame-level reference model (payload list, status bits, counters).
module tb_mac_rx_parser;
  localparam logic [47:0] MAC  = 48'h02_00_00_00_00_01;
  localparam int          MINP = 46;
  localparam int          MAXP = 1500;
  localparam int          CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxdv = 1'b0;
  logic [7:0]    rxd = 8'h00;
  logic          rxer = 1'b0;
  logic          out_valid, out_last, out_hdr_valid, out_done;
  logic [7:0]    out_data;
  logic [47:0]   out_dest_mac, out_src_mac;
  logic [15:0]   out_ether_type;
  logic [3:0]    out_status;
  logic [CW-1:0] out_frames_ok, out_frames_bad;

  mac_rx_parser #(.MAC_ADDR(MAC), .PROMISC(1'b0), .MIN_PAYLOAD(MINP),
                  .MAX_PAYLOAD(MAXP), .CNT_W(CW)) dut (
    .in_rxc(clk), .in_rst_n(rst_n), .in_rxdv(rxdv), .in_rxd(rxd), .in_rxer(rxer),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_hdr_valid(out_hdr_valid), .out_dest_mac(out_dest_mac), .out_src_mac(out_src_mac),
    .out_ether_type(out_ether_type), .out_done(out_done), .out_status(out_status),
    .out_frames_ok(out_frames_ok), .out_frames_bad(out_frames_bad));

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // observed
  logic [7:0]  got_data_q[$];
  bit          got_last_q[$];
  logic [3:0]  got_st_q[$];
  int          got_hdr_n = 0;
  logic [47:0] got_dest, got_src;
  logic [15:0] got_type;
  int          last_cyc = 0, done_cyc = 0, first_v_cyc = 0, pay_drive_cyc = 0;
  // expected
  logic [7:0]  exp_data_q[$];
  bit          exp_last_q[$];
  logic [3:0]  exp_st_q[$];
  int          exp_hdr_n = 0;
  logic [47:0] exp_dest, exp_src;
  logic [15:0] exp_type;
  int          exp_ok = 0, exp_bad = 0;

  logic [7:0]  fr_q[$];     // wire bytes after the SFD: dest .. FCS
  logic [7:0]  saved_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (got_data_q.size() == 0) first_v_cyc = cyc;
        got_data_q.push_back(out_data);
        got_last_q.push_back(out_last);
        if (out_last) last_cyc = cyc;
      end
      if (out_done) begin
        got_st_q.push_back(out_status);
        done_cyc = cyc;
      end
      if (out_hdr_valid) begin
        got_hdr_n++;
        got_dest = out_dest_mac;
        got_src  = out_src_mac;
        got_type = out_ether_type;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Standard Ethernet FCS of fr_q[0..len-1], bit-serial.
  function automatic logic [31:0] fcs_of(input int len);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++)
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ fr_q[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    return ~c;
  endfunction

  task automatic build(input logic [47:0] dest, input int plen, input bit good);
    logic [31:0] f;
    fr_q.delete();
    for (int i = 0; i < 6; i++) fr_q.push_back(dest[47-8*i -: 8]);
    for (int i = 0; i < 8; i++) fr_q.push_back(8'($urandom));
    for (int i = 0; i < plen; i++) fr_q.push_back(8'($urandom));
    f = fcs_of(fr_q.size());
    for (int i = 0; i < 4; i++) fr_q.push_back(f[8*i +: 8]);
    if (!good) fr_q[fr_q.size()-1] = fr_q[fr_q.size()-1] ^ 8'hFF;
  endtask

  // Frame-level reference: what one frame in fr_q should produce.
  task automatic expect_frame(input int rxer_idx);
    int n, p, emit;
    bit crc_bad, len, phy, miss;
    logic [47:0] d;
    logic [3:0] st;
    n = fr_q.size();
    crc_bad = (n < 4) ? 1'b1 :
              (fcs_of(n-4) != {fr_q[n-1], fr_q[n-2], fr_q[n-3], fr_q[n-4]});
    phy = (rxer_idx >= 0) && (rxer_idx < n);
    miss = 1'b0; len = 1'b0; emit = 0;
    if (n < 14) begin
      len = 1'b1;
    end else begin
      d = {fr_q[0], fr_q[1], fr_q[2], fr_q[3], fr_q[4], fr_q[5]};
      exp_hdr_n++;
      exp_dest = d;
      exp_src  = {fr_q[6], fr_q[7], fr_q[8], fr_q[9], fr_q[10], fr_q[11]};
      exp_type = {fr_q[12], fr_q[13]};
      miss = (d != MAC) && (fr_q[0][0] == 1'b0);
      if (n - 14 < 5) len = 1'b1;
      else begin
        p = n - 18;
        emit = (p > MAXP) ? MAXP : p;
        len = (p < MINP) || (p > MAXP);
      end
      if (!miss)
        for (int i = 0; i < emit; i++) begin
          exp_data_q.push_back(fr_q[14+i]);
          exp_last_q.push_back(i == emit - 1);
        end
    end
    st = {crc_bad, len, phy, miss};
    exp_st_q.push_back(st);
    if (st == 4'h0) exp_ok++;
    else            exp_bad++;
  endtask

  task automatic send(input int npre, input logic [7:0] sfd, input int rxer_idx,
                      input int gap, input int cut);
    int n;
    n = (cut >= 0) ? cut : fr_q.size();
    for (int i = 0; i < npre; i++) begin
      rxdv = 1'b1; rxd = 8'h55; rxer = 1'b0; @(negedge clk);
    end
    rxdv = 1'b1; rxd = sfd; @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rxd  = fr_q[i];
      rxer = (i == rxer_idx) ? 1'b1 : 1'b0;
      if (i == 14) pay_drive_cyc = cyc + 1;
      @(negedge clk);
    end
    if (cut < 0) begin
      rxdv = 1'b0; rxd = 8'h00; rxer = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic clear_all();
    got_data_q.delete(); got_last_q.delete(); got_st_q.delete();
    exp_data_q.delete(); exp_last_q.delete(); exp_st_q.delete();
    got_hdr_n = 0; exp_hdr_n = 0;
  endtask

  task automatic check_all(input string tag);
    int dm, lm;
    chk({tag, "_count"}, got_data_q.size(), exp_data_q.size());
    dm = 0; lm = 0;
    for (int i = 0; i < exp_data_q.size(); i++) begin
      if (i >= got_data_q.size()) begin dm++; lm++; end
      else begin
        if (got_data_q[i] !== exp_data_q[i]) dm++;
        if (got_last_q[i] != exp_last_q[i]) lm++;
      end
    end
    chk({tag, "_data"}, dm, 0);
    chk({tag, "_last"}, lm, 0);
    chk({tag, "_ndone"}, got_st_q.size(), exp_st_q.size());
    for (int i = 0; i < exp_st_q.size(); i++)
      chk({tag, "_status"}, (i < got_st_q.size()) ? got_st_q[i] : 4'hx, exp_st_q[i]);
    chk({tag, "_nhdr"}, got_hdr_n, exp_hdr_n);
    if (exp_hdr_n > 0) begin
      chk({tag, "_dest"}, got_dest, exp_dest);
      chk({tag, "_src"}, got_src, exp_src);
      chk({tag, "_type"}, got_type, exp_type);
    end
    chk({tag, "_ok"}, out_frames_ok, exp_ok);
    chk({tag, "_bad"}, out_frames_bad, exp_bad);
    clear_all();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] rd;
    int pl, ri;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_done", out_done, 1'b0);
    chk("rst_status", out_status, 4'h0);
    chk("rst_ok", out_frames_ok, 0);
    chk("rst_bad", out_frames_bad, 0);
    chk("rst_dest", out_dest_mac, 48'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: minimum good frame
    build(MAC, 46, 1'b1); saved_q = fr_q;
    expect_frame(-1); send(7, 8'hD5, -1, 6, -1);
    chk("t1_latency", first_v_cyc - pay_drive_cyc, 5);
    chk("t1_done_after_last", done_cyc - last_cyc, 1);
    check_all("t1");

    // 2: same frame, FCS corrupted
    fr_q = saved_q; fr_q[fr_q.size()-1] = fr_q[fr_q.size()-1] ^ 8'hFF;
    expect_frame(-1); send(7, 8'hD5, -1, 6, -1); check_all("t2");

    // 3: unicast miss, then broadcast and multicast
    build(48'h02_00_00_00_00_02, 50, 1'b1); expect_frame(-1); send(7, 8'hD5, -1, 6, -1); check_all("t3_miss");
    build(48'hFF_FF_FF_FF_FF_FF, 50, 1'b1); expect_frame(-1); send(7, 8'hD5, -1, 6, -1); check_all("t3_bcast");
    build(48'h01_00_5E_00_00_01, 47, 1'b1); expect_frame(-1); send(3, 8'hD5, -1, 6, -1); check_all("t3_mcast");

    // 4: PHY error mid-payload, short payloads
    build(MAC, 46, 1'b1); expect_frame(24); send(7, 8'hD5, 24, 6, -1); check_all("t4_rxer");
    build(MAC, 20, 1'b1); expect_frame(-1); send(7, 8'hD5, -1, 6, -1); check_all("t4_short");
    build(MAC, 45, 1'b1); expect_frame(-1); send(7, 8'hD5, -1, 6, -1); check_all("t4_min_m1");
    build(MAC, 0, 1'b1);  expect_frame(-1); send(7, 8'hD5, -1, 6, -1); check_all("t4_nopay");
    build(MAC, 46, 1'b1); while (fr_q.size() > 10) void'(fr_q.pop_back());
    expect_frame(-1); send(7, 8'hD5, -1, 6, -1); check_all("t4_hdr_cut");

    // 5: oversize and exact maximum
    build(MAC, 1600, 1'b1); expect_frame(-1); send(7, 8'hD5, -1, 6, -1); check_all("t5_over");
    build(MAC, 1500, 1'b1); expect_frame(-1); send(7, 8'hD5, -1, 6, -1); check_all("t5_max");

    // back-to-back frames, rxdv low for a single cycle
    build(MAC, 46, 1'b1); expect_frame(-1); send(7, 8'hD5, -1, 1, -1);
    build(MAC, 52, 1'b1); expect_frame(-1); send(7, 8'hD5, -1, 6, -1); check_all("b2b");

    // randomized frames
    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 3))
        0: rd = MAC;
        1: rd = 48'h02_00_00_00_00_02;
        2: rd = 48'hFF_FF_FF_FF_FF_FF;
        default: rd = {8'h01, 40'($urandom)};
      endcase
      pl = $urandom_range(0, 70);
      ri = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14 + pl + 3) : -1;
      build(rd, pl, ($urandom_range(0, 3) != 0));
      expect_frame(ri); send($urandom_range(1, 7), 8'hD5, ri, 4, -1);
      check_all("rand");
    end

    // 6: bad preambles produce nothing
    build(MAC, 46, 1'b1); send(1, 8'h54, -1, 6, -1); check_all("t6_pre54");
    build(MAC, 46, 1'b1); send(8, 8'hD5, -1, 6, -1); check_all("t6_pre8");

    // 6: reset mid-payload, then a clean frame
    build(MAC, 46, 1'b1); send(7, 8'hD5, -1, 0, 30);
    rst_n = 1'b0; rxdv = 1'b0; rxd = 8'h00;
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_ok", out_frames_ok, 0);
    chk("t6_rst_dest", out_dest_mac, 48'h0);
    chk("t6_rst_status", out_status, 4'h0);
    @(negedge clk);
    clear_all(); exp_ok = 0; exp_bad = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_rst_nodone", got_st_q.size(), 0);
    build(MAC, 60, 1'b1); expect_frame(-1); send(7, 8'hD5, -1, 6, -1); check_all("t6_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
